// File: rtl/multi_channel_sequencer_if.sv
// Output stream of the pattern sequencer: packed lane word with valid/ready handshake.
// The master drives data and valid; the slave returns ready.
interface multi_channel_sequencer_if #(
   parameter int DATA_WIDTH = 16,
   parameter int CHANNELS   = 2
);
   logic [CHANNELS*DATA_WIDTH-1:0] data_out;
   logic                           valid_out;
   logic                           ready_in;

   modport master (output data_out, output valid_out, input ready_in);
   modport slave  (input data_out, input valid_out, output ready_in);
endinterface

// File: rtl/multi_channel_sequencer.sv
// Multi-lane pattern playback: per-lane sample RAMs replayed over an address window,
// with repetition, inter-word wait, downstream backpressure, stop and a done pulse.
module multi_channel_sequencer #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 9,
   parameter int CHANNELS   = 2,
   localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] write_addr,
   input  logic [CH_W-1:0]       write_ch,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  write_en,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [ADDR_WIDTH:0]   data_num,
   input  logic [31:0]           repetition,
   input  logic [31:0]           wait_num,
   input  logic                  kick,
   input  logic                  stop,
   output logic                  busy,
   output logic                  done,
   multi_channel_sequencer_if.master stream
);
   localparam int DEPTH  = 2 ** ADDR_WIDTH;
   localparam int DW_ALL = CHANNELS * DATA_WIDTH;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_OUT   = 2'd2;
   localparam logic [1:0] S_WAIT  = 2'd3;

   logic [1:0]            state;
   logic [ADDR_WIDTH-1:0] start_q, num_m1, idx, nidx, rd_idx, rd_addr;
   logic [31:0]           rep_m1, wait_q, wait_cnt, pass_cnt;
   logic                  loop_q, ram_vld, rd_en, accept, last_word, last_pass;
   logic [DW_ALL-1:0]     ram_q, data_q;
   logic                  valid_q, busy_q, done_q;

   for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
      logic [DATA_WIDTH-1:0] mem [DEPTH];
      logic [DATA_WIDTH-1:0] q;
      always_ff @(posedge clk) begin
         if (write_en && write_ch == CH_W'(k))
            mem[write_addr] <= write_data;
         if (rd_en)
            q <= mem[rd_addr];
      end
      assign ram_q[k*DATA_WIDTH +: DATA_WIDTH] = q;
   end

   assign accept    = (state == S_OUT) && stream.ready_in;
   assign last_word = (idx == num_m1);
   assign last_pass = !loop_q && (pass_cnt == rep_m1);
   assign nidx      = last_word ? '0 : idx + 1'b1;

   // The FETCH cycle already counts as one idle cycle, so wait_num of 0 or 1 reads at accept
   // and longer waits issue the read from WAIT one cycle before the word is due.
   always_comb begin
      rd_en  = 1'b0;
      rd_idx = idx;
      case (state)
         S_FETCH: rd_en = !ram_vld;
         S_OUT: begin
            if (accept && !(last_word && last_pass) && wait_q <= 32'd1) begin
               rd_en  = 1'b1;
               rd_idx = nidx;
            end
         end
         S_WAIT:  rd_en = (wait_cnt == '0);
         default: rd_en = 1'b0;
      endcase
      if (stop)
         rd_en = 1'b0;
   end

   assign rd_addr = start_q + rd_idx;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         start_q  <= '0;
         num_m1   <= '0;
         rep_m1   <= '0;
         wait_q   <= '0;
         loop_q   <= 1'b0;
         idx      <= '0;
         pass_cnt <= '0;
         wait_cnt <= '0;
         ram_vld  <= 1'b0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         ram_vld <= rd_en;
         if (stop && state != S_IDLE) begin
            state   <= S_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (kick && data_num != '0) begin
                     start_q  <= start_addr;
                     num_m1   <= ADDR_WIDTH'(data_num - 1'b1);
                     rep_m1   <= repetition - 1'b1;
                     loop_q   <= (repetition == '0);
                     wait_q   <= wait_num;
                     idx      <= '0;
                     pass_cnt <= '0;
                     busy_q   <= 1'b1;
                     state    <= S_FETCH;
                  end
               end
               // Entered from IDLE without a read in flight; the read comes from latched config.
               S_FETCH: begin
                  if (ram_vld) begin
                     data_q  <= ram_q;
                     valid_q <= 1'b1;
                     state   <= S_OUT;
                  end
               end
               S_OUT: begin
                  if (accept) begin
                     valid_q <= 1'b0;
                     idx     <= nidx;
                     if (last_word)
                        pass_cnt <= pass_cnt + 1'b1;
                     if (last_word && last_pass) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= S_IDLE;
                     end else if (wait_q <= 32'd1) begin
                        state <= S_FETCH;
                     end else begin
                        wait_cnt <= wait_q - 32'd2;
                        state    <= S_WAIT;
                     end
                  end
               end
               default: begin
                  if (wait_cnt == '0)
                     state <= S_FETCH;
                  else
                     wait_cnt <= wait_cnt - 1'b1;
               end
            endcase
         end
      end
   end

   assign busy             = busy_q;
   assign done             = done_q;
   assign stream.data_out  = data_q;
   assign stream.valid_out = valid_q;
endmodule

// File: tb/tb_multi_channel_sequencer.sv
// Directed bench for multi_channel_sequencer: fills both lanes, replays windows and
// checks beat data, spacing, backpressure, stop, ignored kicks and mid-run reset.
module tb_multi_channel_sequencer;
   localparam int DW = 16;
   localparam int AW = 9;
   localparam int CH = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [AW-1:0] write_addr = '0;
   logic [0:0]    write_ch = '0;
   logic [DW-1:0] write_data = '0;
   logic          write_en = 1'b0;
   logic [AW-1:0] start_addr = '0;
   logic [AW:0]   data_num = '0;
   logic [31:0]   repetition = '0;
   logic [31:0]   wait_num = '0;
   logic          kick = 1'b0;
   logic          stop = 1'b0;
   logic          busy, done;

   multi_channel_sequencer_if #(.DATA_WIDTH(DW), .CHANNELS(CH)) bus ();

   multi_channel_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CHANNELS(CH)) dut (
      .clk        (clk),
      .reset      (reset),
      .write_addr (write_addr),
      .write_ch   (write_ch),
      .write_data (write_data),
      .write_en   (write_en),
      .start_addr (start_addr),
      .data_num   (data_num),
      .repetition (repetition),
      .wait_num   (wait_num),
      .kick       (kick),
      .stop       (stop),
      .busy       (busy),
      .done       (done),
      .stream     (bus)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          done_cnt = 0;
   int          done0;
   logic [31:0] beat_q[$];
   int          beat_cyc[$];
   logic [31:0] held;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!reset && bus.valid_out && bus.ready_in) begin
         beat_q.push_back(bus.data_out);
         beat_cyc.push_back(cyc);
      end
      if (done)
         done_cnt <= done_cnt + 1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_word(input int a);
      logic [15:0] a16;
      a16 = 16'(a);
      return {16'h2000 + a16, 16'h1000 + a16};
   endfunction

   function automatic logic [31:0] beat(input int i);
      return (i < beat_q.size()) ? beat_q[i] : 32'hDEAD_BEEF;
   endfunction

   function automatic int gap(input int i);
      return (i < beat_cyc.size()) ? beat_cyc[i] - beat_cyc[i-1] : -1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input int lane, input int addr, input logic [DW-1:0] d);
      write_ch   = 1'(lane);
      write_addr = AW'(addr);
      write_data = d;
      write_en   = 1'b1;
      tick();
      write_en   = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int k = 0;
      while (busy && k < budget) begin
         tick();
         k++;
      end
      check(tag, busy, 1'b0);
   endtask

   task automatic do_kick(input int s, input int n, input int r, input int w);
      beat_q.delete();
      beat_cyc.delete();
      done0      = done_cnt;
      start_addr = AW'(s);
      data_num   = (AW+1)'(n);
      repetition = 32'(r);
      wait_num   = 32'(w);
      kick       = 1'b1;
      tick();
      kick       = 1'b0;
   endtask

   initial begin
      int addrs[22];
      int k;
      bus.ready_in = 1'b1;

      repeat (3) tick();
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_valid", bus.valid_out, 1'b0);
      check("rst_data", bus.data_out, 32'h0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 20; i++) addrs[i] = i;
      addrs[20] = 510;
      addrs[21] = 511;
      for (int i = 0; i < 22; i++) begin
         write_word(0, addrs[i], 16'h1000 + 16'(addrs[i]));
         write_word(1, addrs[i], 16'h2000 + 16'(addrs[i]));
      end

      // Single beat: busy after kick edge, valid two edges later, done on accept.
      do_kick(0, 1, 1, 0);
      check("t1_busy_k", busy, 1'b1);
      check("t1_valid_k", bus.valid_out, 1'b0);
      tick();
      check("t1_valid_k1", bus.valid_out, 1'b0);
      tick();
      check("t1_valid_k2", bus.valid_out, 1'b1);
      check("t1_data", bus.data_out, 32'h2000_1000);
      tick();
      check("t1_valid_end", bus.valid_out, 1'b0);
      check("t1_busy_end", busy, 1'b0);
      check("t1_done", done, 1'b1);
      tick();
      check("t1_done_pulse", done, 1'b0);

      // Window 3..7, three passes, two idle cycles between beats.
      do_kick(3, 5, 3, 2);
      wait_idle("t2_idle", 200);
      tick();
      check("t2_count", beat_q.size(), 15);
      for (int i = 0; i < 15; i++) begin
         check($sformatf("t2_beat%0d", i), beat(i), exp_word(3 + i % 5));
         if (i > 0) check($sformatf("t2_gap%0d", i), gap(i), 3);
      end
      check("t2_done", done_cnt - done0, 1);

      // Address wrap past the top of the memory.
      do_kick(510, 4, 1, 0);
      wait_idle("t3_idle", 100);
      tick();
      check("t3_count", beat_q.size(), 4);
      check("t3_beat0", beat(0), exp_word(510));
      check("t3_beat1", beat(1), exp_word(511));
      check("t3_beat2", beat(2), exp_word(0));
      check("t3_beat3", beat(3), exp_word(1));
      for (int i = 1; i < 4; i++) check($sformatf("t3_gap%0d", i), gap(i), 2);

      // Backpressure held on the second beat.
      do_kick(0, 5, 1, 0);
      k = 0;
      while (beat_q.size() < 1 && k < 50) begin tick(); k++; end
      bus.ready_in = 1'b0;
      k = 0;
      while (!bus.valid_out && k < 50) begin tick(); k++; end
      held = bus.data_out;
      check("t4_held", held, exp_word(1));
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("t4_valid_hold%0d", i), bus.valid_out, 1'b1);
         check($sformatf("t4_data_hold%0d", i), bus.data_out, held);
      end
      check("t4_no_accept", beat_q.size(), 1);
      bus.ready_in = 1'b1;
      wait_idle("t4_idle", 100);
      tick();
      check("t4_count", beat_q.size(), 5);
      for (int i = 0; i < 5; i++) check($sformatf("t4_beat%0d", i), beat(i), exp_word(i));

      // Infinite loop, then stop.
      do_kick(0, 5, 0, 1);
      repeat (40) tick();
      check("t5_busy_loop", busy, 1'b1);
      check("t5_many", beat_q.size() >= 10, 1'b1);
      check("t5_beat7", beat(7), exp_word(2));
      check("t5_gap7", gap(7), 2);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("t5_valid_stop", bus.valid_out, 1'b0);
      check("t5_busy_stop", busy, 1'b0);
      tick();
      check("t5_no_done", done_cnt - done0, 0);

      // Kick while busy is ignored; config may change after the kick edge.
      do_kick(0, 3, 1, 2);
      repeat (2) tick();
      start_addr = AW'(10);
      data_num   = (AW+1)'(1);
      kick       = 1'b1;
      tick();
      kick       = 1'b0;
      wait_idle("t6_idle", 100);
      tick();
      check("t6_count", beat_q.size(), 3);
      for (int i = 0; i < 3; i++) check($sformatf("t6_beat%0d", i), beat(i), exp_word(i));
      check("t6_done", done_cnt - done0, 1);

      // Kick with zero length is ignored.
      do_kick(0, 0, 1, 0);
      check("t6_num0_busy", busy, 1'b0);
      repeat (4) tick();
      check("t6_num0_valid", bus.valid_out, 1'b0);
      check("t6_num0_done", done_cnt - done0, 0);

      // Reset in the middle of a run.
      do_kick(0, 5, 0, 0);
      repeat (9) tick();
      reset = 1'b1;
      tick();
      check("t7_busy", busy, 1'b0);
      check("t7_valid", bus.valid_out, 1'b0);
      check("t7_data", bus.data_out, 32'h0);
      check("t7_done", done, 1'b0);
      reset = 1'b0;
      repeat (3) tick();
      check("t7_idle", busy, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end
endmodule
